// File: rtl/fifo_stream_reader.sv
// Drain side of SyncFIFO: pulls WIDTH-bit words and emits them LSB-first as
// NSLICE beats of SLICE bits, with hold + prefetch buffering to hide read latency.
module fifo_stream_reader #(
  parameter int WIDTH  = 3072,
  parameter int SLICE  = 256,
  parameter int NSLICE = WIDTH / SLICE,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SLICE-1:0] m_data,
  output logic             m_last,
  output logic [IDX_W-1:0] m_idx,
  output logic             busy
);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("fifo_stream_reader: WIDTH must be a multiple of SLICE");
    end
    if (NSLICE < 2 || NSLICE != WIDTH / SLICE) begin : g_bad_nslice
      $error("fifo_stream_reader: NSLICE must equal WIDTH/SLICE and be >= 2");
    end
    if ((2 ** IDX_W) < NSLICE) begin : g_bad_idx
      $error("fifo_stream_reader: IDX_W too narrow for NSLICE");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_pref;
  logic             r_hv;
  logic             r_pv;
  logic             r_inflight;
  logic [IDX_W-1:0] r_idx;

  logic             w_acc;
  logic             w_rel;
  logic             w_last;
  logic [1:0]       w_occ;
  logic             w_cap_hold;
  logic [SLICE-1:0] w_slice;

  assign w_last = r_hv && (r_idx == LAST_IDX);
  assign w_acc  = r_hv && m_ready;
  assign w_rel  = w_acc && w_last;

  // Occupancy after this cycle's release; rel implies hv, so no underflow.
  assign w_occ     = 2'(r_hv) + 2'(r_pv) + 2'(r_inflight) - 2'(w_rel);
  assign fifo_rinc = !fifo_rempty && (w_occ < 2'd2);

  assign w_cap_hold = (!r_hv || w_rel) && !r_pv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv       <= 1'b0;
      r_pv       <= 1'b0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_inflight <= fifo_rinc;
      if (w_acc) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (r_inflight) begin
        if (w_cap_hold) begin
          r_hv <= 1'b1;
        end else if (!(r_pv && w_rel)) begin
          r_pv <= 1'b1;
        end
      end else if (w_rel) begin
        if (r_pv) begin
          r_pv <= 1'b0;
        end else begin
          r_hv <= 1'b0;
        end
      end
    end
  end

  // Word storage needs no reset: contents are only observed while hv/pv are set.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      if (w_cap_hold) begin
        r_hold <= fifo_rdata;
      end else if (r_pv && w_rel) begin
        r_hold <= r_pref;
        r_pref <= fifo_rdata;
      end else begin
        r_pref <= fifo_rdata;
      end
    end else if (w_rel && r_pv) begin
      r_hold <= r_pref;
    end
  end

  always_comb begin
    w_slice = '0;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_slice = r_hold[k*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    m_valid = r_hv;
    m_data  = r_hv ? w_slice : '0;
    m_last  = w_last;
    m_idx   = r_idx;
    busy    = r_hv || r_pv || r_inflight;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: two instances (32/8 and 3072/256),
// each fed by a small behavioural SyncFIFO with 1-cycle read latency.
module tb_fifo_stream_reader;

  localparam int AW = 32;
  localparam int AS = 8;
  localparam int AN = 4;
  localparam int BW = 3072;
  localparam int BS = 256;
  localparam int BN = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: WIDTH=32, SLICE=8 ----------------
  logic          a_rempty = 1'b1;
  logic          a_rinc;
  logic [AW-1:0] a_rdata  = '0;
  logic          a_valid;
  logic          a_ready;
  logic [AS-1:0] a_data;
  logic          a_last;
  logic [3:0]    a_idx;
  logic          a_busy;

  fifo_stream_reader #(.WIDTH(AW), .SLICE(AS), .NSLICE(AN), .IDX_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_rempty(a_rempty), .fifo_rinc(a_rinc),
    .fifo_rdata(a_rdata), .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data),
    .m_last(a_last), .m_idx(a_idx), .busy(a_busy)
  );

  logic [AW-1:0] mem_a [64];
  int unsigned   wr_a = 0;
  int unsigned   rd_a = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a     <= wr_a;
      a_rempty <= 1'b1;
    end else begin
      if (a_rinc) begin
        a_rdata <= mem_a[rd_a[5:0]];
        rd_a    <= rd_a + 1;
      end
      a_rempty <= (rd_a + 32'(a_rinc) == wr_a);
    end
  end

  int unsigned   sb_a = 0, ka = 0, beats_a = 0, rinc_a = 0;
  logic [AW-1:0] exp_a_w;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_a = wr_a;
      ka   = 0;
    end else begin
      if (a_rempty) chk("a_rinc_while_empty", 256'(a_rinc), 256'(0));
      if (a_rinc) rinc_a++;
      if (a_valid && a_ready) begin
        chk("a_word_pending", 256'(sb_a < wr_a), 256'(1));
        exp_a_w = mem_a[sb_a[5:0]];
        chk("a_beat_data", 256'(a_data), 256'(exp_a_w[ka*AS +: AS]));
        chk("a_beat_idx", 256'(a_idx), 256'(ka));
        chk("a_beat_last", 256'(a_last), 256'(ka == AN - 1));
        if (ka == AN - 1) begin
          ka = 0;
          sb_a++;
        end else begin
          ka++;
        end
        beats_a++;
      end
    end
  end

  // ---------------- instance B: WIDTH=3072, SLICE=256 ----------------
  logic          b_rempty = 1'b1;
  logic          b_rinc;
  logic [BW-1:0] b_rdata  = '0;
  logic          b_valid;
  logic          b_ready;
  logic [BS-1:0] b_data;
  logic          b_last;
  logic [3:0]    b_idx;
  logic          b_busy;

  fifo_stream_reader #(.WIDTH(BW), .SLICE(BS), .NSLICE(BN), .IDX_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_rempty(b_rempty), .fifo_rinc(b_rinc),
    .fifo_rdata(b_rdata), .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
    .m_last(b_last), .m_idx(b_idx), .busy(b_busy)
  );

  logic [BW-1:0] mem_b [128];
  int unsigned   wr_b = 0;
  int unsigned   rd_b = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_b     <= wr_b;
      b_rempty <= 1'b1;
    end else begin
      if (b_rinc) begin
        b_rdata <= mem_b[rd_b[6:0]];
        rd_b    <= rd_b + 1;
      end
      b_rempty <= (rd_b + 32'(b_rinc) == wr_b);
    end
  end

  int unsigned   sb_b = 0, kb = 0, beats_b = 0;
  logic [BW-1:0] exp_b_w;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_b = wr_b;
      kb   = 0;
    end else begin
      if (b_rempty) chk("b_rinc_while_empty", 256'(b_rinc), 256'(0));
      if (b_valid && b_ready) begin
        chk("b_word_pending", 256'(sb_b < wr_b), 256'(1));
        exp_b_w = mem_b[sb_b[6:0]];
        chk("b_beat_data", b_data, exp_b_w[kb*BS +: BS]);
        chk("b_beat_idx", 256'(b_idx), 256'(kb));
        chk("b_beat_last", 256'(b_last), 256'(kb == BN - 1));
        if (kb == BN - 1) begin
          kb = 0;
          sb_b++;
        end else begin
          kb++;
        end
        beats_b++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [AW-1:0] w);
    mem_a[wr_a[5:0]] = w;
    wr_a++;
  endtask

  task automatic push_b(input logic [BW-1:0] w);
    mem_b[wr_b[6:0]] = w;
    wr_b++;
  endtask

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int j = 0; j < BW / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  logic [AW-1:0] stream_w [4] = '{32'h13579BDF, 32'h2468ACE0, 32'hF0E1D2C3, 32'h0F1E2D3C};
  logic [AW-1:0] bp_w     [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};

  initial begin
    int unsigned   base_r, base_b;
    int            t_r, t_v, n_v, first_v, last_v;
    logic [BW-1:0] fresh;
    logic          seen;

    a_ready = 1'b0;
    b_ready = 1'b0;

    // Reset defaults
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_rinc", 256'(a_rinc), 256'(0));
    chk("rst_a_valid", 256'(a_valid), 256'(0));
    chk("rst_a_last", 256'(a_last), 256'(0));
    chk("rst_a_idx", 256'(a_idx), 256'(0));
    chk("rst_a_busy", 256'(a_busy), 256'(0));
    chk("rst_a_data", 256'(a_data), 256'(0));
    chk("rst_b_valid", 256'(b_valid), 256'(0));
    chk("rst_b_data", b_data, 256'(0));
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      chk("idle_rinc", 256'(a_rinc), 256'(0));
      chk("idle_valid", 256'(a_valid), 256'(0));
    end

    // Single word
    a_ready = 1'b1;
    base_r = rinc_a; base_b = beats_a; t_r = -1; t_v = -1;
    push_a(32'hDDCCBBAA);
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      if (a_rinc && t_r < 0) t_r = c;
      if (a_valid && t_v < 0) t_v = c;
    end
    chk("single_latency", 256'(t_v - t_r), 256'(2));
    chk("single_rinc_pulses", 256'(rinc_a - base_r), 256'(1));
    chk("single_beats", 256'(beats_a - base_b), 256'(4));
    chk("single_busy_after", 256'(a_busy), 256'(0));

    // Back-to-back stream
    base_r = rinc_a; base_b = beats_a; n_v = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < 40; c++) begin
      step(); #1;
      if (a_valid) begin
        n_v++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (c < 4) push_a(stream_w[c]);
    end
    chk("stream_valid_cycles", 256'(n_v), 256'(16));
    chk("stream_no_gap", 256'(last_v - first_v + 1), 256'(16));
    chk("stream_rinc_pulses", 256'(rinc_a - base_r), 256'(4));
    chk("stream_beats", 256'(beats_a - base_b), 256'(16));

    // Backpressure
    a_ready = 1'b0;
    base_r = rinc_a; base_b = beats_a;
    for (int c = 0; c < 14; c++) begin
      step(); #1;
      if (a_valid) chk("bp_hold_data", 256'(a_data), 256'(8'h11));
      if (c < 4) push_a(bp_w[c]);
    end
    chk("bp_rinc_pulses", 256'(rinc_a - base_r), 256'(2));
    chk("bp_valid", 256'(a_valid), 256'(1));
    chk("bp_data", 256'(a_data), 256'(8'h11));
    chk("bp_idx", 256'(a_idx), 256'(0));
    chk("bp_no_beats", 256'(beats_a - base_b), 256'(0));
    a_ready = 1'b1;
    repeat (30) step();
    #1;
    chk("bp_drain_beats", 256'(beats_a - base_b), 256'(16));
    chk("bp_drain_words", 256'(sb_a), 256'(wr_a));
    chk("bp_drain_busy", 256'(a_busy), 256'(0));

    // Random backpressure, 100 wide words
    base_b = beats_b;
    for (int i = 0; i < 100; i++) push_b(rand_word());
    for (int c = 0; c < 8000 && (beats_b - base_b) < 1200; c++) begin
      step();
      b_ready = 1'($urandom_range(0, 1));
    end
    b_ready = 1'b1;
    repeat (4) step();
    #1;
    chk("rand_beats", 256'(beats_b - base_b), 256'(1200));
    chk("rand_words", 256'(sb_b), 256'(wr_b));
    chk("rand_busy_after", 256'(b_busy), 256'(0));

    // Reset in the middle of a word
    base_b = beats_b;
    push_b(rand_word());
    for (int c = 0; c < 40 && (beats_b - base_b) < 5; c++) begin
      step(); #1;
    end
    chk("mid_beats_before_rst", 256'(beats_b - base_b), 256'(5));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(b_valid), 256'(0));
    chk("mid_rst_busy", 256'(b_busy), 256'(0));
    chk("mid_rst_idx", 256'(b_idx), 256'(0));
    repeat (2) step();
    rst_n = 1'b1;
    fresh = rand_word();
    push_b(fresh);
    base_b = beats_b; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(); #1;
      if (b_valid && !seen) begin
        seen = 1'b1;
        chk("mid_first_idx", 256'(b_idx), 256'(0));
        chk("mid_first_data", b_data, fresh[BS-1:0]);
      end
    end
    chk("mid_new_word_seen", 256'(seen), 256'(1));
    chk("mid_new_beats", 256'(beats_b - base_b), 256'(12));
    chk("mid_new_words", 256'(sb_b), 256'(wr_b));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
